// File: rtl/xaddr_decoder_nslv_if.sv
// Bus bundle between the core data port, the address decoder and its N_SLV slaves.
// The slave modport is the decoder's view; the master modport is the surrounding core/slave side.
interface xaddr_decoder_nslv_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int N_SLV  = 4
);
  logic [ADDR_W-1:0]       addr;
  logic                    sel;
  logic                    ready;
  logic                    err;
  logic [DATA_W-1:0]       data_to_rd;
  logic [N_SLV-1:0]        slv_sel;
  logic [N_SLV-1:0]        slv_ready;
  logic [N_SLV*DATA_W-1:0] slv_data_to_rd;

  modport master (
    output addr, sel, slv_ready, slv_data_to_rd,
    input  ready, err, data_to_rd, slv_sel
  );

  modport slave (
    input  addr, sel, slv_ready, slv_data_to_rd,
    output ready, err, data_to_rd, slv_sel
  );
endinterface

// File: rtl/xaddr_decoder_nslv.sv
// Registered address decoder / read-data router for N_SLV power-of-two slave regions,
// with wait-state handshake, access timeout and sticky trap. Optional fault log: XDEC_TRAP_LOG_EN.
module xaddr_decoder_nslv #(
  parameter int                      ADDR_W      = 16,
  parameter int                      DATA_W      = 32,
  parameter int                      N_SLV       = 4,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE    = {16'hC000, 16'h8000, 16'h4000, 16'h0000},
  parameter logic [N_SLV*8-1:0]      SLV_AW      = {8'd8, 8'd8, 8'd10, 8'd12},
  parameter int                      TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                rst,
  xaddr_decoder_nslv_if.slave bus,
  output logic                trap_sel,
  input  logic                trap_clr
`ifdef XDEC_TRAP_LOG_EN
  ,
  output logic [ADDR_W-1:0]   trap_addr,
  output logic                trap_cause
`endif
);

  localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [N_SLV-1:0]   slv_sel_reg, slv_sel_next;
  logic               ready_reg, ready_next;
  logic               err_reg, err_next;
  logic [DATA_W-1:0]  data_reg, data_next;
  logic               trap_reg, trap_next;
  logic               trap_set;
  logic               fault_cause;

  logic [N_SLV-1:0]   hit;
  logic [IDX_W-1:0]   hit_idx;
  logic               any_hit;
  logic               cur_ready;
  logic [DATA_W-1:0]  cur_data;

  // Region match: clear the offset bits of the address and compare with the base.
  genvar gi;
  generate
    for (gi = 0; gi < N_SLV; gi++) begin : g_match
      localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
      localparam logic [ADDR_W-1:0] MASK = ~((ONE << SLV_AW[gi*8 +: 8]) - ONE);
      assign hit[gi] = ((bus.addr & MASK) == SLV_BASE[gi*ADDR_W +: ADDR_W]);
    end
  endgenerate

  // Scan downwards so the lowest matching index is the one left standing.
  always_comb begin
    hit_idx = '0;
    any_hit = 1'b0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_idx = IDX_W'(i);
        any_hit = 1'b1;
      end
    end
  end

  assign cur_ready = bus.slv_ready[idx_reg];
  assign cur_data  = bus.slv_data_to_rd[idx_reg*DATA_W +: DATA_W];

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    cnt_next     = cnt_reg;
    slv_sel_next = slv_sel_reg;
    ready_next   = 1'b0;
    err_next     = err_reg;
    data_next    = data_reg;
    trap_set     = 1'b0;
    fault_cause  = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (bus.sel) begin
          if (any_hit) begin
            idx_next     = hit_idx;
            cnt_next     = '0;
            slv_sel_next = N_SLV'(1) << hit_idx;
            state_next   = ACCESS;
          end else begin
            ready_next  = 1'b1;
            err_next    = 1'b1;
            data_next   = '0;
            trap_set    = 1'b1;
            fault_cause = 1'b0;
            state_next  = RESP;
          end
        end
      end

      ACCESS: begin
        if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + 1'b1;
        end
        // Slave completion has priority over a timeout landing in the same cycle.
        if (cur_ready) begin
          ready_next   = 1'b1;
          err_next     = 1'b0;
          data_next    = cur_data;
          slv_sel_next = '0;
          state_next   = RESP;
        end else if (TO_EN && (cnt_reg == TO_LAST)) begin
          ready_next   = 1'b1;
          err_next     = 1'b1;
          data_next    = '0;
          slv_sel_next = '0;
          trap_set     = 1'b1;
          fault_cause  = 1'b1;
          state_next   = RESP;
        end
      end

      RESP: begin
        slv_sel_next = '0;
        state_next   = IDLE;
      end

      default: begin
        slv_sel_next = '0;
        state_next   = IDLE;
      end
    endcase

    trap_next = trap_set | (trap_reg & ~trap_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      cnt_reg     <= '0;
      slv_sel_reg <= '0;
      ready_reg   <= 1'b0;
      err_reg     <= 1'b0;
      data_reg    <= '0;
      trap_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      cnt_reg     <= cnt_next;
      slv_sel_reg <= slv_sel_next;
      ready_reg   <= ready_next;
      err_reg     <= err_next;
      data_reg    <= data_next;
      trap_reg    <= trap_next;
    end
  end

  assign bus.ready      = ready_reg;
  assign bus.err        = err_reg;
  assign bus.data_to_rd = data_reg;
  assign bus.slv_sel    = slv_sel_reg;
  assign trap_sel       = trap_reg;

`ifdef XDEC_TRAP_LOG_EN
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W-1:0] trap_addr_reg, trap_addr_next;
  logic              trap_cause_reg, trap_cause_next;
  logic              log_load;

  // The first fault is kept until software has cleared the trap flag.
  always_comb begin
    addr_next       = addr_reg;
    trap_addr_next  = trap_addr_reg;
    trap_cause_next = trap_cause_reg;
    if ((state_reg == IDLE) && bus.sel) begin
      addr_next = bus.addr;
    end
    log_load = trap_set & (~trap_reg | trap_clr);
    if (log_load) begin
      trap_addr_next  = fault_cause ? addr_reg : bus.addr;
      trap_cause_next = fault_cause;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg       <= '0;
      trap_addr_reg  <= '0;
      trap_cause_reg <= 1'b0;
    end else begin
      addr_reg       <= addr_next;
      trap_addr_reg  <= trap_addr_next;
      trap_cause_reg <= trap_cause_next;
    end
  end

  assign trap_addr  = trap_addr_reg;
  assign trap_cause = trap_cause_reg;
`endif

endmodule

// File: tb/tb_xaddr_decoder_nslv.sv
// Directed self-checking bench for xaddr_decoder_nslv: mapped, wait-state, timeout,
// unmapped/trap and asynchronous-reset cases on the default 4-slave memory map.
module tb_xaddr_decoder_nslv;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int N_SLV  = 4;

  logic clk;
  logic rst;
  logic trap_sel;
  logic trap_clr;
`ifdef XDEC_TRAP_LOG_EN
  logic [ADDR_W-1:0] trap_addr;
  logic              trap_cause;
`endif

  int n_total = 0;
  int n_bad   = 0;

  xaddr_decoder_nslv_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_SLV(N_SLV)) bus ();

  xaddr_decoder_nslv #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_SLV(N_SLV), .TIMEOUT_CYC(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .trap_sel (trap_sel),
    .trap_clr (trap_clr)
`ifdef XDEC_TRAP_LOG_EN
    ,
    .trap_addr  (trap_addr),
    .trap_cause (trap_cause)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_timeout(input bit late_ready, input logic [31:0] exp_data, input logic exp_err);
    bus.addr = 16'h8004;
    bus.sel  = 1'b1;
    step();
    bus.sel = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      chk("to_slv_sel", 64'(bus.slv_sel), 64'(4'b0100));
      chk("to_no_ready", 64'(bus.ready), 64'd0);
      if (k == 16 && late_ready) bus.slv_ready = 4'b0100;
      step();
    end
    bus.slv_ready = 4'b0000;
    chk("to_ready", 64'(bus.ready), 64'd1);
    chk("to_err", 64'(bus.err), 64'(exp_err));
    chk("to_data", 64'(bus.data_to_rd), 64'(exp_data));
    chk("to_slv_sel_off", 64'(bus.slv_sel), 64'd0);
    chk("to_trap", 64'(trap_sel), 64'd1);
`ifdef XDEC_TRAP_LOG_EN
    chk("to_cause", 64'(trap_cause), 64'd1);
    chk("to_taddr", 64'(trap_addr), 64'h8004);
`endif
    $display("txn timeout late_ready=%0b ready=%0b err=%0b data=%h trap=%0b",
             late_ready, bus.ready, bus.err, bus.data_to_rd, trap_sel);
    step();
    chk("to_ready_drop", 64'(bus.ready), 64'd0);
  endtask

  initial begin
    rst                = 1'b1;
    trap_clr           = 1'b0;
    bus.addr           = '0;
    bus.sel            = 1'b0;
    bus.slv_ready      = '0;
    bus.slv_data_to_rd = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_ready", 64'(bus.ready), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_data", 64'(bus.data_to_rd), 64'd0);
    chk("rst_slv_sel", 64'(bus.slv_sel), 64'd0);
    chk("rst_trap", 64'(trap_sel), 64'd0);

    // Zero-wait read from slave 1.
    bus.slv_data_to_rd[1*DATA_W +: DATA_W] = 32'hCAFE0001;
    bus.slv_ready = 4'b0010;
    bus.addr = 16'h4010;
    bus.sel  = 1'b1;
    step();
    bus.sel = 1'b0;
    chk("zw_slv_sel", 64'(bus.slv_sel), 64'(4'b0010));
    chk("zw_ready_c1", 64'(bus.ready), 64'd0);
    step();
    chk("zw_ready", 64'(bus.ready), 64'd1);
    chk("zw_err", 64'(bus.err), 64'd0);
    chk("zw_data", 64'(bus.data_to_rd), 64'hCAFE0001);
    chk("zw_trap", 64'(trap_sel), 64'd0);
    chk("zw_slv_sel_off", 64'(bus.slv_sel), 64'd0);
    $display("txn zero-wait addr=4010 ready=%0b err=%0b data=%h", bus.ready, bus.err, bus.data_to_rd);
    step();
    chk("zw_one_cycle", 64'(bus.ready), 64'd0);
    bus.slv_ready = 4'b0000;

    // Wait states on slave 0, completion in the third access cycle.
    bus.slv_data_to_rd[0*DATA_W +: DATA_W] = 32'h12345678;
    bus.addr = 16'h0FFF;
    bus.sel  = 1'b1;
    step();
    bus.sel = 1'b0;
    chk("ws_slv_sel_c1", 64'(bus.slv_sel), 64'(4'b0001));
    step();
    chk("ws_slv_sel_c2", 64'(bus.slv_sel), 64'(4'b0001));
    chk("ws_ready_c2", 64'(bus.ready), 64'd0);
    step();
    chk("ws_slv_sel_c3", 64'(bus.slv_sel), 64'(4'b0001));
    chk("ws_ready_c3", 64'(bus.ready), 64'd0);
    bus.slv_ready = 4'b0001;
    step();
    bus.slv_ready = 4'b0000;
    chk("ws_ready", 64'(bus.ready), 64'd1);
    chk("ws_err", 64'(bus.err), 64'd0);
    chk("ws_data", 64'(bus.data_to_rd), 64'h12345678);
    chk("ws_slv_sel_c4", 64'(bus.slv_sel), 64'd0);
    $display("txn wait-state addr=0fff ready=%0b err=%0b data=%h", bus.ready, bus.err, bus.data_to_rd);
    step();

    // Timeout with no slave response, then completion in the final cycle.
    bus.slv_data_to_rd[2*DATA_W +: DATA_W] = 32'hA5A50002;
    run_timeout(1'b0, 32'h0, 1'b1);
    run_timeout(1'b1, 32'hA5A50002, 1'b0);

    trap_clr = 1'b1;
    step();
    trap_clr = 1'b0;
    chk("clr_trap", 64'(trap_sel), 64'd0);
    $display("txn trap-clear trap=%0b", trap_sel);

    // Unmapped accesses and trap-log retention.
    bus.addr = 16'h2000;
    bus.sel  = 1'b1;
    step();
    bus.sel = 1'b0;
    chk("um_ready", 64'(bus.ready), 64'd1);
    chk("um_err", 64'(bus.err), 64'd1);
    chk("um_trap", 64'(trap_sel), 64'd1);
    chk("um_slv_sel", 64'(bus.slv_sel), 64'd0);
`ifdef XDEC_TRAP_LOG_EN
    chk("um_taddr", 64'(trap_addr), 64'h2000);
    chk("um_cause", 64'(trap_cause), 64'd0);
`endif
    $display("txn unmapped addr=2000 ready=%0b err=%0b trap=%0b", bus.ready, bus.err, trap_sel);
    step();
    chk("um_ready_drop", 64'(bus.ready), 64'd0);

    bus.addr = 16'hC100;
    bus.sel  = 1'b1;
    step();
    bus.sel = 1'b0;
    chk("um2_ready", 64'(bus.ready), 64'd1);
    chk("um2_err", 64'(bus.err), 64'd1);
`ifdef XDEC_TRAP_LOG_EN
    chk("um2_taddr_kept", 64'(trap_addr), 64'h2000);
`endif
    $display("txn unmapped addr=c100 ready=%0b err=%0b trap=%0b", bus.ready, bus.err, trap_sel);
    step();

    bus.addr = 16'h3000;
    bus.sel  = 1'b1;
    trap_clr = 1'b1;
    step();
    bus.sel  = 1'b0;
    trap_clr = 1'b0;
    chk("setclr_trap", 64'(trap_sel), 64'd1);
    chk("setclr_err", 64'(bus.err), 64'd1);
`ifdef XDEC_TRAP_LOG_EN
    chk("setclr_taddr", 64'(trap_addr), 64'h3000);
`endif
    $display("txn unmapped+clear addr=3000 trap=%0b", trap_sel);
    step();

    // Asynchronous reset while an access is in flight.
    bus.addr = 16'h0000;
    bus.sel  = 1'b1;
    step();
    bus.sel = 1'b0;
    chk("rm_slv_sel_pre", 64'(bus.slv_sel), 64'(4'b0001));
    #2;
    rst = 1'b1;
    #1;
    chk("rm_slv_sel", 64'(bus.slv_sel), 64'd0);
    chk("rm_ready", 64'(bus.ready), 64'd0);
    chk("rm_trap", 64'(trap_sel), 64'd0);
    chk("rm_err", 64'(bus.err), 64'd0);
    $display("txn reset-mid-access slv_sel=%b trap=%0b", bus.slv_sel, trap_sel);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    bus.slv_data_to_rd[0*DATA_W +: DATA_W] = 32'h0BADF00D;
    bus.slv_ready = 4'b0001;
    bus.addr = 16'h0000;
    bus.sel  = 1'b1;
    step();
    bus.sel = 1'b0;
    chk("ra_slv_sel", 64'(bus.slv_sel), 64'(4'b0001));
    step();
    chk("ra_ready", 64'(bus.ready), 64'd1);
    chk("ra_err", 64'(bus.err), 64'd0);
    chk("ra_data", 64'(bus.data_to_rd), 64'h0BADF00D);
    $display("txn post-reset addr=0000 ready=%0b err=%0b data=%h", bus.ready, bus.err, bus.data_to_rd);
    bus.slv_ready = 4'b0000;
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/xaddr_decoder_nslv.md
Name: xaddr_decoder_nslv

Overview:
Parametrised, registered address decoder and read-data router between the core's single master port and N_SLV slave regions.
- Each slave has its own base and power-of-two region size.
- Adds wait-state handshake, per-access timeout and a sticky trap status for unmapped or stalled accesses.
- Sits between the core data port and the memory, register-file, external and peripheral (LED etc.) slaves.

Parameters:
- ADDR_W, 16, master address width.
- DATA_W, 32, data width.
- N_SLV, 4, number of slave regions (1..16).
- SLV_BASE, {16'hC000,16'h8000,16'h4000,16'h0000}, packed N_SLV*ADDR_W; slave i base at [i*ADDR_W +: ADDR_W].
- SLV_AW, {8'd8,8'd8,8'd10,8'd12}, packed N_SLV*8; slave i offset width (region = 2^SLV_AW[i] words).
- TIMEOUT_CYC, 16, max cycles waiting for slave ready; 0 disables timeout.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- addr  in  ADDR_W  master address, sampled when accepted
- sel  in  1  master request
- ready  out  1  one-cycle response strobe to master
- err  out  1  qualifies ready: access failed (unmapped or timeout)
- data_to_rd  out  DATA_W  registered read data, valid with ready
- slv_sel  out  N_SLV  one-hot slave select
- slv_ready  in  N_SLV  per-slave completion
- slv_data_to_rd  in  N_SLV*DATA_W  packed slave read data, slave i at [i*DATA_W +: DATA_W]
- trap_sel  out  1  sticky trap flag
- trap_clr  in  1  clears trap_sel

Behaviour:
- Reset (async, any state): FSM -> IDLE; ready, err, slv_sel, trap_sel = 0; data_to_rd = 0; timeout counter = 0.
- Match rule: slave i hits when (addr & ~((1<<SLV_AW[i])-1)) == SLV_BASE[i]. Lowest index wins on overlap. No hit = unmapped.
- FSM states:
  - IDLE
    - sel=1 and hit: latch slave index, counter=0, go ACCESS.
    - sel=1 and unmapped: go RESP with err=1, trap set.
    - sel=0: stay.
  - ACCESS
    - slv_sel[idx]=1 (registered, one-hot); counter increments each cycle.
    - slv_ready[idx]=1: capture slv_data_to_rd[idx] into data_to_rd, go RESP, err=0.
    - Else if TIMEOUT_CYC!=0 and counter==TIMEOUT_CYC-1: go RESP, err=1, data_to_rd=0, trap set.
    - slv_ready of non-selected slaves ignored.
  - RESP
    - ready=1 for exactly one cycle; slv_sel=0; go IDLE.
    - err and data_to_rd held until the next response.
- Latency: sel sampled in IDLE at cycle 0, slv_sel asserted cycle 1. With zero-wait slave, ready at cycle 2. Unmapped: ready+err at cycle 1.
- Throughput: new request accepted only in IDLE, so min 3 cycles per mapped access; sel held high through RESP is re-sampled in IDLE.
- sel dropped or addr changed during ACCESS: access completes on latched index.
- slv_ready asserted in the same cycle the timeout expires: ready wins (err=0).
- trap_sel: set on unmapped or timeout response. trap_clr clears it. Set and clear in the same cycle: set wins.
- Counter width $clog2(TIMEOUT_CYC+1). Counter saturates and never wraps.

Optional Feature:
Macro XDEC_TRAP_LOG_EN.
- Defined: adds outputs trap_addr (ADDR_W) and trap_cause (1; 0=unmapped, 1=timeout).
  - Loaded only when trap_sel is 0 or being cleared that cycle (first fault kept).
  - Reset to 0; not cleared by trap_clr, only overwritten by the next fault.
- Undefined: ports and registers absent; trap_sel behaviour unchanged.

Test Plan:
- Zero-wait read: sel=1, addr=16'h4010, slv_ready[1] tied 1, slv data 32'hCAFE0001 -> slv_sel=4'b0010 at cycle 1; ready=1, err=0, data_to_rd=32'hCAFE0001 at cycle 2; trap_sel=0.
- Wait states: addr=16'h0FFF, slv_ready[0] raised on 3rd ACCESS cycle, data 32'h12345678 -> ready at cycle 4 with that data; slv_sel=4'b0001 for cycles 1-3 only.
- Unmapped: addr=16'h2000 -> ready=1, err=1 at cycle 1; trap_sel=1. With XDEC_TRAP_LOG_EN: trap_addr=16'h2000, trap_cause=0.
  - Then addr=16'hC100 (unmapped) -> trap_addr stays 16'h2000.
  - Then trap_clr with a simultaneous new fault -> trap_sel stays 1.
- Timeout: TIMEOUT_CYC=16, addr=16'h8004, slv_ready=0 -> slv_sel[2] high 16 cycles, then ready=1, err=1, data_to_rd=0, trap_sel=1, trap_cause=1.
  - Repeat with slv_ready[2] in the 16th cycle -> err=0.
- Reset mid-access: assert rst during ACCESS -> slv_sel, ready, trap_sel drop to 0 asynchronously.
  - After release, addr=16'h0000 access completes normally in 2 cycles.
